// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execute stage: ALU select codes and the EX/MEM bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

    // Datapath width that the EX/MEM bundle fields are sized to.
    // The ex_stage WIDTH parameter must match this value.
    localparam int XLEN = 32;

    // ALU select codes produced by alu_control_unit (fixed encoding).
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;  // signed add (ADD/ADDI), may overflow-trap
    localparam logic [2:0] ALU_SLT  = 3'b011;
    localparam logic [2:0] ALU_ADDU = 3'b100;
    localparam logic [2:0] ALU_SLL  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;  // SUB, SUBU and branch compare share this code
    localparam logic [2:0] ALU_SLTU = 3'b111;

    // EX/MEM pipeline register contents.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] result;
        logic            zero;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic [XLEN-1:0] store_data;
    } ex_mem_t;

endpackage

// File: rtl/alu32.sv
// Combinational ALU for the execute stage; also flags signed overflow on ALU_ADD.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   sel    - ALU select code (see mips_pkg)
//   op_a   - rs operand
//   op_b   - rt operand or sign-extended immediate
//   shamt  - shift amount for SLL
//   result - ALU result, modulo 2^WIDTH
//   ovf    - signed overflow of ALU_ADD; constant 0 unless EX_OVF_TRAP_EN is defined
module alu32
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [4:0]       shamt,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             lt_signed;
    logic             lt_unsigned;

    // Carry-out is intentionally dropped: all add/sub is modulo 2^WIDTH.
    assign sum         = op_a + op_b;
    assign diff        = op_a - op_b;
    assign lt_signed   = $signed(op_a) < $signed(op_b);
    assign lt_unsigned = op_a < op_b;

    always_comb begin
        result = '0;
        case (sel)
            ALU_AND:  result = op_a & op_b;
            ALU_OR:   result = op_a | op_b;
            ALU_ADD:  result = sum;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, lt_signed};
            ALU_ADDU: result = sum;
            ALU_SLL:  result = op_b << shamt;
            ALU_SUB:  result = diff;
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, lt_unsigned};
            default:  result = '0;
        endcase
    end

`ifdef EX_OVF_TRAP_EN
    // Only ADD traps. SUB shares its code with SUBU, so it can never trap.
    // Overflow: operands agree in sign and the sum's sign differs from them.
    assign ovf = (sel == ALU_ADD)
              && (op_a[WIDTH-1] == op_b[WIDTH-1])
              && (sum[WIDTH-1] != op_a[WIDTH-1]);
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: runs the ALU and registers result plus controls into EX/MEM.
// Latency: 1 cycle from ID/EX inputs to EX/MEM outputs.
// Backpressure: stall holds EX/MEM (ovf_exc forced low); flush inserts a bubble and beats stall.
//
// Optional feature macro: EX_OVF_TRAP_EN (signed-overflow trap on ALU_ADD).
//
// Ports:
//   clk, rst_n                       - clock, asynchronous active-low reset
//   in_valid                         - ID/EX slot holds a real instruction
//   stall, flush                     - hold / bubble the EX/MEM register
//   sel, op_a, op_b, shamt           - ALU select and operands
//   rd_in, reg_write_in, mem_read_in,
//   mem_write_in, store_data_in      - pass-through destination, controls, store data
//   out_*                            - registered EX/MEM bundle
//   ovf_exc                          - one-cycle overflow exception pulse
module ex_stage
    import mips_pkg::*;
#(
    parameter int WIDTH = 32  // must equal mips_pkg::XLEN (the EX/MEM bundle is sized from it)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [4:0]       shamt,
    input  logic [4:0]       rd_in,
    input  logic             reg_write_in,
    input  logic             mem_read_in,
    input  logic             mem_write_in,
    input  logic [WIDTH-1:0] store_data_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic [4:0]       out_rd,
    output logic             out_reg_write,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic [WIDTH-1:0] out_store_data,
    output logic             ovf_exc
);

    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf;
    logic             trap;
    ex_mem_t          cap;
    ex_mem_t          ex_mem_q;
    logic             ovf_q;

    alu32 #(
        .WIDTH (WIDTH)
    ) u_alu (
        .sel    (sel),
        .op_a   (op_a),
        .op_b   (op_b),
        .shamt  (shamt),
        .result (alu_result),
        .ovf    (alu_ovf)
    );

`ifdef EX_OVF_TRAP_EN
    // A trap only matters for a real instruction; bubbles never raise it.
    assign trap = in_valid & alu_ovf;
`else
    // No overflow handling: ADD behaves exactly like ADDU.
    logic unused_alu_ovf;
    assign unused_alu_ovf = alu_ovf;
    assign trap           = 1'b0;
`endif

    // Value the EX/MEM register takes on a normal (unstalled, unflushed) edge.
    // A trapping instruction stays valid with its wrapped sum, but must not
    // write a register or touch memory.
    always_comb begin
        cap            = '0;
        cap.valid      = in_valid;
        cap.result     = alu_result;
        cap.zero       = (alu_result == '0);  // from the ALU, never from out_result
        cap.rd         = rd_in;
        cap.reg_write  = in_valid & reg_write_in & ~trap;
        cap.mem_read   = in_valid & mem_read_in  & ~trap;
        cap.mem_write  = in_valid & mem_write_in & ~trap;
        cap.store_data = store_data_in;
    end

    // Priority: flush > stall > capture. On flush the data fields simply hold,
    // since nothing downstream looks at them without valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_mem_q <= '0;
            ovf_q    <= 1'b0;
        end else if (flush) begin
            ex_mem_q.valid     <= 1'b0;
            ex_mem_q.reg_write <= 1'b0;
            ex_mem_q.mem_read  <= 1'b0;
            ex_mem_q.mem_write <= 1'b0;
            ovf_q              <= 1'b0;
        end else if (stall) begin
            // EX/MEM holds; the pulse must not repeat while held.
            ovf_q <= 1'b0;
        end else begin
            ex_mem_q <= cap;
            ovf_q    <= trap;
        end
    end

    assign out_valid      = ex_mem_q.valid;
    assign out_result     = ex_mem_q.result;
    assign out_zero       = ex_mem_q.zero;
    assign out_rd         = ex_mem_q.rd;
    assign out_reg_write  = ex_mem_q.reg_write;
    assign out_mem_read   = ex_mem_q.mem_read;
    assign out_mem_write  = ex_mem_q.mem_write;
    assign out_store_data = ex_mem_q.store_data;
    assign ovf_exc        = ovf_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed steps plus randomized traffic vs a behavioural model.
// Latency: model expects results one clock after the inputs are sampled.
// Backpressure: stall/flush are exercised directly and randomly.
module tb_ex_stage;

`ifdef EX_OVF_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic [2:0]  sel;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic [4:0]  rd_in;
    logic        reg_write_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [31:0] store_data_in;
    logic        out_valid;
    logic [31:0] out_result;
    logic        out_zero;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic [31:0] out_store_data;
    logic        ovf_exc;

    ex_stage #(.WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .stall          (stall),
        .flush          (flush),
        .sel            (sel),
        .op_a           (op_a),
        .op_b           (op_b),
        .shamt          (shamt),
        .rd_in          (rd_in),
        .reg_write_in   (reg_write_in),
        .mem_read_in    (mem_read_in),
        .mem_write_in   (mem_write_in),
        .store_data_in  (store_data_in),
        .out_valid      (out_valid),
        .out_result     (out_result),
        .out_zero       (out_zero),
        .out_rd         (out_rd),
        .out_reg_write  (out_reg_write),
        .out_mem_read   (out_mem_read),
        .out_mem_write  (out_mem_write),
        .out_store_data (out_store_data),
        .ovf_exc        (ovf_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the EX/MEM slot.
    logic        m_valid, m_zero, m_rw, m_mr, m_mw, m_ovf;
    logic [31:0] m_result, m_sd;
    logic [4:0]  m_rd;
    bit          m_known;  // data fields are defined (not after a flush)

    logic [31:0] sweep_exp [8];

    // ALU written from the instruction semantics using wide signed arithmetic.
    function automatic logic [31:0] ref_alu(input logic [2:0] s, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        longint r;
        case (s)
            3'd0:    r = ua & ub;
            3'd1:    r = ua | ub;
            3'd2:    r = sa + sb;
            3'd3:    r = (sa < sb) ? 1 : 0;
            3'd4:    r = ua + ub;
            3'd5:    r = ub * (longint'(1) << sh);
            3'd6:    r = ua - ub;
            default: r = (ua < ub) ? 1 : 0;
        endcase
        return r[31:0];
    endfunction

    // True when the mathematical signed sum does not fit in 32 bits.
    function automatic bit ref_ovf(input logic [31:0] a, input logic [31:0] b);
        longint s = longint'($signed(a)) + longint'($signed(b));
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_zero = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_ovf = 0;
        m_result = 0; m_sd = 0; m_rd = 0; m_known = 1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, m_valid});
        chk({tag, ".reg_write"}, {31'd0, out_reg_write}, {31'd0, m_rw});
        chk({tag, ".mem_read"}, {31'd0, out_mem_read}, {31'd0, m_mr});
        chk({tag, ".mem_write"}, {31'd0, out_mem_write}, {31'd0, m_mw});
        chk({tag, ".ovf_exc"}, {31'd0, ovf_exc}, {31'd0, m_ovf});
        if (m_known) begin
            chk({tag, ".result"}, out_result, m_result);
            chk({tag, ".zero"}, {31'd0, out_zero}, {31'd0, m_zero});
            chk({tag, ".rd"}, {27'd0, out_rd}, {27'd0, m_rd});
            chk({tag, ".store_data"}, out_store_data, m_sd);
        end
    endtask

    // Drive one cycle of inputs, advance the model, clock, then check 1 ns after the edge.
    task automatic step(input string tag, input logic v, input logic st, input logic fl,
                        input logic [2:0] s, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [4:0] rd, input logic rw,
                        input logic mr, input logic mw, input logic [31:0] sd);
        logic [31:0] res;
        bit          o;
        in_valid = v; stall = st; flush = fl; sel = s; op_a = a; op_b = b; shamt = sh;
        rd_in = rd; reg_write_in = rw; mem_read_in = mr; mem_write_in = mw; store_data_in = sd;
        if (fl) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_ovf = 0; m_known = 0;
        end else if (st) begin
            m_ovf = 0;
        end else begin
            res      = ref_alu(s, a, b, sh);
            o        = TRAP && v && (s == 3'd2) && ref_ovf(a, b);
            m_valid  = v;
            m_result = res;
            m_zero   = (res == 32'd0);
            m_rd     = rd;
            m_rw     = v & rw & !o;
            m_mr     = v & mr & !o;
            m_mw     = v & mw & !o;
            m_sd     = sd;
            m_ovf    = o;
            m_known  = 1;
        end
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic rand_step(input string tag);
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom;
        if ($urandom_range(0, 3) == 0) a = 32'h7FFF_FFF0 | ($urandom & 32'hF);
        if ($urandom_range(0, 3) == 0) b = $urandom & 32'h1F;
        if ($urandom_range(0, 5) == 0) b = a;
        step(tag, $urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0,
             $urandom_range(0, 9) == 0, 3'($urandom), a, b, 5'($urandom), 5'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    endtask

    initial begin
        sweep_exp[0] = 32'h0000_0000;
        sweep_exp[1] = 32'h0000_00FF;
        sweep_exp[2] = 32'h0000_00FF;
        sweep_exp[3] = 32'h0000_0001;
        sweep_exp[4] = 32'h0000_00FF;
        sweep_exp[5] = 32'h0000_0F00;
        sweep_exp[6] = 32'hFFFF_FF1F;
        sweep_exp[7] = 32'h0000_0001;

        // Reset held with random inputs toggling.
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom); stall = 1'($urandom); flush = 1'($urandom);
            sel = 3'($urandom); op_a = $urandom; op_b = $urandom; shamt = 5'($urandom);
            rd_in = 5'($urandom); reg_write_in = 1'($urandom); mem_read_in = 1'($urandom);
            mem_write_in = 1'($urandom); store_data_in = $urandom;
            @(posedge clk);
            #1;
        end
        check_model("reset");

        // Release; a stalled cycle must keep everything at zero.
        rst_n = 1'b1;
        step("post_reset", 1, 1, 0, 3'd2, 32'd5, 32'd6, 5'd1, 5'd9, 1, 1, 1, 32'hABCD);

        // ALU sweep on every select code.
        for (int s = 0; s < 8; s++) begin
            step("sweep", 1, 0, 0, 3'(s), 32'h0000_000F, 32'h0000_00F0, 5'd4, 5'(s), 1, 0, 0,
                 32'h5555_0000 + s);
            chk("sweep_tbl", out_result, sweep_exp[s]);
            chk("sweep_zero", {31'd0, out_zero}, (s == 0) ? 32'd1 : 32'd0);
        end

        // Branch compare through SUB.
        step("beq_eq", 1, 0, 0, 3'd6, 32'h1234, 32'h1234, 5'd0, 5'd0, 0, 0, 0, 32'd0);
        chk("beq_eq_zero", {31'd0, out_zero}, 32'd1);
        chk("beq_eq_res", out_result, 32'd0);
        step("beq_ne", 1, 0, 0, 3'd6, 32'h1234, 32'h1235, 5'd0, 5'd0, 0, 0, 0, 32'd0);
        chk("beq_ne_zero", {31'd0, out_zero}, 32'd0);

        // Signed overflow on ADD, then a clean ADD to end the pulse.
        step("ovf_add", 1, 0, 0, 3'd2, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd3, 1, 0, 0, 32'd0);
        chk("ovf_res", out_result, 32'h8000_0000);
        chk("ovf_rw", {31'd0, out_reg_write}, TRAP ? 32'd0 : 32'd1);
        chk("ovf_exc", {31'd0, ovf_exc}, TRAP ? 32'd1 : 32'd0);
        chk("ovf_valid", {31'd0, out_valid}, 32'd1);
        step("ovf_after", 1, 0, 0, 3'd2, 32'd1, 32'd1, 5'd0, 5'd3, 1, 0, 0, 32'd0);
        chk("ovf_pulse_end", {31'd0, ovf_exc}, 32'd0);
        // Back-to-back overflows.
        step("ovf_b2b_0", 1, 0, 0, 3'd2, 32'h8000_0000, 32'h8000_0000, 5'd0, 5'd4, 1, 1, 0, 32'd0);
        step("ovf_b2b_1", 1, 0, 0, 3'd2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd0, 5'd5, 1, 0, 1, 32'd0);
        // ADDU and SUB never trap.
        step("addu_no", 1, 0, 0, 3'd4, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd6, 1, 0, 0, 32'd0);
        chk("addu_no_exc", {31'd0, ovf_exc}, 32'd0);
        step("sub_no", 1, 0, 0, 3'd6, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0, 5'd6, 1, 0, 0, 32'd0);
        chk("sub_no_exc", {31'd0, ovf_exc}, 32'd0);
        // Flush in the same cycle as an overflow: no pulse.
        step("ovf_flush", 1, 0, 1, 3'd2, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd7, 1, 0, 0, 32'd0);
        chk("ovf_flush_exc", {31'd0, ovf_exc}, 32'd0);

        // Stall holds a captured ADD 3+4 while inputs change.
        step("stall_cap", 1, 0, 0, 3'd2, 32'd3, 32'd4, 5'd0, 5'd8, 1, 0, 0, 32'h77);
        for (int i = 0; i < 2; i++) begin
            step("stall_hold", 1'($urandom), 1, 0, 3'($urandom), $urandom, $urandom,
                 5'($urandom), 5'($urandom), 1, 1, 1, $urandom);
            chk("stall_res", out_result, 32'd7);
        end
        // Stall and flush together: flush wins.
        step("stall_flush", 1, 1, 1, 3'd2, 32'd1, 32'd2, 5'd0, 5'd9, 1, 1, 1, 32'd0);
        chk("sf_valid", {31'd0, out_valid}, 32'd0);
        chk("sf_rw", {31'd0, out_reg_write}, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) rand_step("rand");

        // Mid-operation asynchronous reset, sampled away from any clock edge.
        step("pre_rst", 1, 0, 0, 3'd1, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0, 5'd11, 1, 1, 1,
             32'hDEAD_BEEF);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model("async_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the pipelined MIPS core, directly downstream of `alu_control_unit`. It consumes the 3-bit ALU select plus ID/EX operands and control bits, performs the ALU operation, and registers the result and pass-through controls into the EX/MEM pipeline register. It supports stall (hold) and flush (bubble insertion) and can optionally raise a signed-overflow exception.

## Interface
- `WIDTH`, 32, datapath width in bits
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  ID/EX slot holds a real instruction
- `stall`  in  1  hold EX/MEM contents this cycle
- `flush`  in  1  load a bubble into EX/MEM this cycle
- `sel`  in  3  ALU select from `alu_control_unit`
- `op_a`  in  WIDTH  rs operand
- `op_b`  in  WIDTH  rt operand or sign-extended immediate
- `shamt`  in  5  shift amount
- `rd_in`  in  5  destination register
- `reg_write_in`, `mem_read_in`, `mem_write_in`  in  1 each  pass-through controls
- `store_data_in`  in  WIDTH  rt value for stores
- `out_valid`  out  1  EX/MEM slot valid
- `out_result`  out  WIDTH  registered ALU result
- `out_zero`  out  1  registered (result == 0), for branch resolution
- `out_rd`  out  5  registered destination
- `out_reg_write`, `out_mem_read`, `out_mem_write`  out  1 each  registered controls
- `out_store_data`  out  WIDTH  registered store data
- `ovf_exc`  out  1  one-cycle overflow exception pulse

## Operation
- ALU select encoding (fixed): 000 AND, 001 OR, 010 ADD (signed, ADD/ADDI), 011 SLT (signed), 100 ADDU, 101 SLL (`op_b << shamt`), 110 SUB (also SUBU and branch compare), 111 SLTU.
- SLT/SLTU: result = {WIDTH-1 zeros, less-than bit}.
- All add/sub arithmetic is modulo 2^WIDTH; carry discarded.
- Overflow is only ever evaluated for sel 010: operands have the same sign and result sign differs. Sel 110 never traps, because SUB and SUBU share the code.
- When `in_valid`=0, the captured controls (`reg_write`, `mem_read`, `mem_write`) are forced to 0 and `out_valid`=0. Data fields may capture any value.
- Priority per cycle: flush > stall > normal capture.
  - Flush: `out_valid` and all control outputs become 0. Data fields are don't-care.
  - Stall: every output register holds, and `ovf_exc` is held at 0.
  - Normal: all fields load from the inputs and ALU.

## Timing
- Latency: 1 cycle. Inputs sampled at a rising edge appear on the outputs after that edge.
- Reset (asynchronous assert, synchronous-safe release) sets every output to 0, including `out_result`, `out_zero`, and `ovf_exc`.
- Reset asserted mid-operation discards the in-flight instruction. No output holds a stale value after the reset edge.
- `out_zero` is computed from the same-cycle ALU result and registered with it. It is never computed from `out_result`.
- `ovf_exc` is high for exactly one cycle per overflowing valid, unflushed, unstalled capture.
- Back-to-back overflows produce consecutive pulses.
- Flush and overflow in the same cycle: the flush wins and no pulse is produced.

## Configuration
- `EX_OVF_TRAP_EN` defined: on a sel-010 overflow, the captured instruction keeps `out_valid`=1 and `out_result` holds the wrapped sum, but `out_reg_write`, `out_mem_read`, and `out_mem_write` are forced to 0 and `ovf_exc` pulses.
- `EX_OVF_TRAP_EN` undefined: there is no overflow logic, `ovf_exc` is tied to 0, and ADD behaves exactly like ADDU.

## Structure
- Shared package `mips_pkg` holds:
  - the localparams for the eight ALU select codes (`ALU_AND` … `ALU_SLTU`);
  - the EX/MEM bundle typedef (valid, result, zero, rd, controls, store data).
- One sub-module, `alu32`: a purely combinational ALU taking `sel`, `op_a`, `op_b`, and `shamt`, and producing result and overflow. `ex_stage` contains only the pipeline register, the priority logic, and the trap gating.

## Test plan
- Reset: hold `rst_n`=0 with random inputs, then release. All outputs must be 0 until the first capture.
- ALU sweep: apply a=0x0000_000F, b=0x0000_00F0, shamt=4 on each sel.
  - Next cycle `out_result` must be: AND 0x0, OR 0xFF, ADD 0xFF, SLT 1, ADDU 0xFF, SLL 0xF00, SUB 0xFFFF_FF1F, SLTU 1.
  - `out_zero` must be 1 only for AND.
- Branch compare: sel 110 with a=b=0x1234 must give `out_zero`=1 and `out_result`=0. With b=0x1235, it must give `out_zero`=0.
- Overflow: sel 010 with a=0x7FFF_FFFF, b=1 and `reg_write_in`=1.
  - With the macro: result 0x8000_0000, `out_reg_write`=0, and a 1-cycle `ovf_exc`.
  - Without the macro: `out_reg_write`=1 and `ovf_exc`=0.
  - The same operands on sel 100 or 110 never assert `ovf_exc`.
- Stall/flush:
  - Capture ADD 3+4, then assert `stall` for 2 cycles while the inputs change. `out_result` must stay 7.
  - Assert `stall` and `flush` together. `out_valid` and `out_reg_write` must become 0.
- Mid-op reset: drop `rst_n` while `out_valid`=1. All outputs must clear immediately, without waiting for a clock edge.
